// File: rtl/updown_mod_counter_pkg.sv
// Shared encodings, default sizing and parameter legality helper for the
// up/down modulo counter.
package updown_mod_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 5;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Legal modulus: 1 <= max_val <= 2**width-1.
    function automatic bit max_val_ok(input int unsigned width, input longint unsigned max_val);
        longint unsigned top;
        top = (64'd1 << width) - 64'd1;
        return (max_val >= 64'd1) && (max_val <= top);
    endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
interface updown_mod_counter_if #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned STEP_W = WIDTH
);
    logic              load;
    logic              enab;
    logic              up_dn;
    logic              sat_mode;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  cnt_in;
    logic [WIDTH-1:0]  cnt_out;
    logic              tc;
    logic              ovf;
    logic              zero;

    modport master (
        output load, enab, up_dn, sat_mode, step, cnt_in,
        input  cnt_out, tc, ovf, zero
    );

    modport slave (
        input  load, enab, up_dn, sat_mode, step, cnt_in,
        output cnt_out, tc, ovf, zero
    );
endinterface

// File: rtl/counter_next.sv
// Combinational next-count for one step up or down, wrapping modulo MAX_VAL+1
// or saturating at 0/MAX_VAL; bound_hit flags that a limit was crossed.
module counter_next
    import updown_mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned MAX_VAL = (1 << WIDTH) - 1
) (
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic             up_dn_i,
    input  logic             sat_mode_i,
    output logic [WIDTH-1:0] next_c_o,
    output logic             bound_hit_c_o
);
    localparam int unsigned     EW    = WIDTH + 1;
    localparam logic [EW-1:0]   LIM   = EW'(MAX_VAL);
    localparam logic [EW-1:0]   MODV  = EW'(MAX_VAL + 1);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [EW-1:0]    cnt_x;
    logic [EW-1:0]    s_x;
    logic [EW-1:0]    sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] wrap_up;
    logic [WIDTH-1:0] wrap_dn;

    assign cnt_x = {1'b0, cnt_i};
    assign s_x   = {1'b0, s_i};

    // Extra bit keeps cnt+s and cnt+MOD-s exact before the wrap correction.
    always_comb begin
        sum           = cnt_x + s_x;
        diff          = WIDTH'(cnt_x - s_x);
        wrap_up       = WIDTH'(sum - MODV);
        wrap_dn       = WIDTH'(cnt_x + MODV - s_x);
        next_c_o      = cnt_i;
        bound_hit_c_o = 1'b0;
        if (up_dn_i == DIR_UP) begin
            if (sum <= LIM) begin
                next_c_o = sum[WIDTH-1:0];
            end else begin
                bound_hit_c_o = 1'b1;
                next_c_o      = (sat_mode_i == MODE_SAT) ? MAX_W : wrap_up;
            end
        end else begin
            if (s_x <= cnt_x) begin
                next_c_o = diff;
            end else begin
                bound_hit_c_o = 1'b1;
                next_c_o      = (sat_mode_i == MODE_SAT) ? '0 : wrap_dn;
            end
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Loadable up/down counter with programmable step and modulus, wrap/saturate
// at the limits, registered terminal-count pulse and sticky overflow flag.
module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned MAX_VAL = (1 << WIDTH) - 1,
    parameter int unsigned STEP_W  = WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    updown_mod_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    if (!max_val_ok(WIDTH, 64'(MAX_VAL))) begin : g_bad_max_val
        $error("updown_mod_counter: MAX_VAL must be in 1..2**WIDTH-1");
    end
    if (STEP_W > WIDTH) begin : g_bad_step_w
        $error("updown_mod_counter: STEP_W must not exceed WIDTH");
    end

    logic [STEP_W-1:0] step_raw;
    logic [WIDTH-1:0]  step_ext;
    logic [WIDTH-1:0]  step_eff;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  next_cnt;
    logic              bound_hit;

    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic              tc_q, tc_d;
    logic              ovf_q, ovf_d;

    // Clamp both the load value and the step into the legal count range.
    assign step_raw = bus.step;
    assign step_ext = WIDTH'(step_raw);
    assign step_eff = (step_ext > MAX_W) ? MAX_W : step_ext;
    assign load_val = (bus.cnt_in > MAX_W) ? MAX_W : bus.cnt_in;

    counter_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .cnt_i         (cnt_q),
        .s_i           (step_eff),
        .up_dn_i       (bus.up_dn),
        .sat_mode_i    (bus.sat_mode),
        .next_c_o      (next_cnt),
        .bound_hit_c_o (bound_hit)
    );

    // Priority: load over enab over hold; tc only pulses on a counting edge.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        if (bus.load) begin
            cnt_d = load_val;
            ovf_d = 1'b0;
        end else if (bus.enab) begin
            cnt_d = next_cnt;
            tc_d  = bound_hit;
            ovf_d = ovf_q | bound_hit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.cnt_out = cnt_q;
    assign bus.tc      = tc_q;
    assign bus.ovf     = ovf_q;
    assign bus.zero    = (cnt_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: dut_a uses MAX_VAL=20, dut_b the default MAX_VAL=31.
module tb_updown_mod_counter;

    typedef struct {
        int         cyc;
        int         id;
        bit         sel_b;
        logic [4:0] cnt;
        logic       tc;
        logic       ovf;
        logic       zero;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   next_id;
    exp_t q[$];

    updown_mod_counter_if #(.WIDTH(5), .STEP_W(5)) ifa ();
    updown_mod_counter_if #(.WIDTH(5), .STEP_W(5)) ifb ();

    updown_mod_counter #(.WIDTH(5), .MAX_VAL(20), .STEP_W(5)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    updown_mod_counter dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time (errors=%0d)", errors);
        $fatal(1, "watchdog expired");
    end

    function automatic void push(input bit sel_b, input int at_cyc, input logic [4:0] ecnt,
                                 input logic etc, input logic eovf);
        exp_t e;
        e.cyc   = at_cyc;
        e.id    = next_id;
        e.sel_b = sel_b;
        e.cnt   = ecnt;
        e.tc    = etc;
        e.ovf   = eovf;
        e.zero  = (ecnt == 5'd0);
        next_id = next_id + 1;
        q.push_back(e);
    endfunction

    task automatic vec_a(input logic ld, input logic en, input logic ud, input logic sm,
                         input logic [4:0] st, input logic [4:0] ci,
                         input logic [4:0] ecnt, input logic etc, input logic eovf);
        @(negedge clk);
        ifa.load = ld; ifa.enab = en; ifa.up_dn = ud; ifa.sat_mode = sm;
        ifa.step = st; ifa.cnt_in = ci;
        push(1'b0, cyc + 1, ecnt, etc, eovf);
    endtask

    task automatic vec_b(input logic ld, input logic en, input logic ud, input logic sm,
                         input logic [4:0] st, input logic [4:0] ci,
                         input logic [4:0] ecnt, input logic etc, input logic eovf);
        @(negedge clk);
        ifb.load = ld; ifb.enab = en; ifb.up_dn = ud; ifb.sat_mode = sm;
        ifb.step = st; ifb.cnt_in = ci;
        push(1'b1, cyc + 1, ecnt, etc, eovf);
    endtask

    // Monitor: every falling edge, retire all expectations due this cycle.
    initial begin
        exp_t       e;
        logic [4:0] a_cnt;
        logic       a_tc, a_ovf, a_zero;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks = checks + 1;
                if (e.sel_b) begin
                    a_cnt = ifb.cnt_out; a_tc = ifb.tc; a_ovf = ifb.ovf; a_zero = ifb.zero;
                end else begin
                    a_cnt = ifa.cnt_out; a_tc = ifa.tc; a_ovf = ifa.ovf; a_zero = ifa.zero;
                end
                if (e.cyc < cyc) begin
                    errors = errors + 1;
                    $display("FAIL %s#%0d stale: due cycle %0d, seen at cycle %0d",
                             e.sel_b ? "B" : "A", e.id, e.cyc, cyc);
                end else if (a_cnt !== e.cnt || a_tc !== e.tc || a_ovf !== e.ovf || a_zero !== e.zero) begin
                    errors = errors + 1;
                    $display("FAIL %s#%0d got cnt=%0d tc=%b ovf=%b zero=%b, expected cnt=%0d tc=%b ovf=%b zero=%b",
                             e.sel_b ? "B" : "A", e.id, a_cnt, a_tc, a_ovf, a_zero,
                             e.cnt, e.tc, e.ovf, e.zero);
                end
            end
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        next_id = 0;
        rst     = 1'b0;
        ifa.load = 1'b0; ifa.enab = 1'b0; ifa.up_dn = 1'b1; ifa.sat_mode = 1'b0;
        ifa.step = 5'd0; ifa.cnt_in = 5'd0;
        ifb.load = 1'b0; ifb.enab = 1'b0; ifb.up_dn = 1'b1; ifb.sat_mode = 1'b0;
        ifb.step = 5'd0; ifb.cnt_in = 5'd0;

        // Held in reset across the first edge.
        push(1'b0, 1, 5'd0, 1'b0, 1'b0);
        push(1'b1, 1, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        //    ld en ud sm step  cin    cnt   tc  ovf
        vec_a(1, 0, 1, 0, 5'd0, 5'd7,  5'd7,  0, 0);
        vec_a(0, 1, 1, 0, 5'd3, 5'd0,  5'd10, 0, 0);
        vec_a(1, 0, 1, 0, 5'd0, 5'd18, 5'd18, 0, 0);
        vec_a(0, 1, 1, 0, 5'd5, 5'd0,  5'd2,  1, 1);

        // Async reset mid-count with ovf set, observed before the next edge.
        @(negedge clk);
        ifa.load = 1'b0; ifa.enab = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        push(1'b0, cyc, 5'd0, 1'b0, 1'b0);
        push(1'b1, cyc, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        ifa.enab = 1'b1; ifa.up_dn = 1'b1; ifa.sat_mode = 1'b0; ifa.step = 5'd4;
        push(1'b0, cyc + 1, 5'd4, 1'b0, 1'b0);

        vec_a(1, 0, 1, 0, 5'd0,  5'd18, 5'd18, 0, 0);
        vec_a(0, 1, 1, 0, 5'd5,  5'd0,  5'd2,  1, 1);
        vec_a(0, 0, 1, 0, 5'd5,  5'd0,  5'd2,  0, 1);
        vec_a(1, 1, 1, 0, 5'd5,  5'd31, 5'd20, 0, 0);
        vec_a(1, 1, 1, 0, 5'd5,  5'd7,  5'd7,  0, 0);
        vec_a(1, 0, 1, 1, 5'd0,  5'd18, 5'd18, 0, 0);
        vec_a(0, 1, 1, 1, 5'd5,  5'd0,  5'd20, 1, 1);
        vec_a(0, 1, 1, 1, 5'd5,  5'd0,  5'd20, 1, 1);
        vec_a(0, 1, 1, 1, 5'd0,  5'd0,  5'd20, 0, 1);
        vec_a(1, 0, 0, 0, 5'd0,  5'd3,  5'd3,  0, 0);
        vec_a(0, 1, 0, 0, 5'd5,  5'd0,  5'd19, 1, 1);
        vec_a(1, 0, 0, 1, 5'd0,  5'd3,  5'd3,  0, 0);
        vec_a(0, 1, 0, 1, 5'd5,  5'd0,  5'd0,  1, 1);
        vec_a(0, 1, 0, 1, 5'd5,  5'd0,  5'd0,  1, 1);
        vec_a(1, 0, 1, 0, 5'd0,  5'd10, 5'd10, 0, 0);
        vec_a(0, 1, 1, 0, 5'd31, 5'd0,  5'd9,  1, 1);
        vec_a(0, 1, 0, 0, 5'd31, 5'd0,  5'd10, 1, 1);
        vec_a(0, 1, 0, 0, 5'd4,  5'd0,  5'd6,  0, 1);
        vec_a(0, 1, 0, 0, 5'd6,  5'd0,  5'd0,  0, 1);
        vec_a(0, 1, 1, 0, 5'd20, 5'd0,  5'd20, 0, 1);
        vec_a(0, 0, 1, 0, 5'd20, 5'd0,  5'd20, 0, 1);

        // Full modulo-32 lap on the default-parameter counter.
        for (int k = 1; k <= 32; k++) begin
            vec_b(0, 1, 1, 0, 5'd1, 5'd0, 5'(k % 32), (k == 32), (k == 32));
        end
        vec_b(1, 0, 1, 0, 5'd0, 5'd9, 5'd9, 0, 0);

        @(negedge clk);
        ifb.load = 1'b0; ifb.enab = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations never retired, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
